// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SW-bit slice per stage, inter-slice carry
// registered, whole pipe advances together under a valid/ready handshake.
module cla_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          cmsb
);
  localparam int NG = SW / 4;

  logic [SW-1:0] p, g, c;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;

  // 4-bit group G/P feed the group carry chain; bit carries are expanded from each group carry-in.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c  = '0;
    gg = '0;
    gp = '0;
    gc = '0;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign s    = p ^ c;
  assign co   = gc[NG];
  assign cmsb = c[SW-1];
endmodule

module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ofl,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cmsb;
    logic             sub;
    logic             sign;
  } op_t;

  logic            adv;
  logic [STAGES:1] vld_pipe;
  op_t             cap, last_n, last_q;
  logic            ofl_q, zero_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    cap      = '0;
    cap.a    = a;
    cap.b    = sub ? ~b : b;
    cap.c    = sub ? 1'b1 : cin;
    cap.sub  = sub;
    cap.sign = sign;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Each stage carries the untouched upper operand bits forward and fills in its own sum slice.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    op_t           d, n, q;
    logic [SW-1:0] ss;
    logic          sc, sm;

    if (k == 0) begin : g_first
      assign d = cap;
    end else begin : g_next
      assign d = g_stage[k-1].q;
    end

    cla_slice #(.SW(SW)) u_slice (
      .a    (d.a[k*SW +: SW]),
      .b    (d.b[k*SW +: SW]),
      .ci   (d.c),
      .s    (ss),
      .co   (sc),
      .cmsb (sm)
    );

    always_comb begin
      n = d;
      n.s[k*SW +: SW] = ss;
      n.c    = sc;
      n.cmsb = sm;
    end

    always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else if (adv) q <= n;
    end
  end

  assign last_n = g_stage[STAGES-1].n;
  assign last_q = g_stage[STAGES-1].q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ofl_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      zero_q <= (last_n.s == '0);
      ofl_q  <= last_n.sign ? (last_n.cmsb ^ last_n.c) : (last_n.c ^ last_n.sub);
    end
  end

  // Operand copies and mode bits are dead once the last slice has been resolved.
  logic unused_tail;
  assign unused_tail = ^{last_q.a, last_q.b, last_q.cmsb, last_q.sub, last_q.sign};

  assign out_valid = vld_pipe[STAGES];
  assign sum       = last_q.s;
  assign cout      = last_q.c;
  assign ofl       = ofl_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Exercises three adder configurations side by side against a queue-based arithmetic model
// that tracks how many advances each accepted operation still needs before it reaches the output.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar ci = 0; ci < 3; ci++) begin : g_cfg
    localparam int W = (ci == 0) ? 16 : (ci == 1) ? 32 : 8;
    localparam int S = (ci == 0) ? 4 : (ci == 1) ? 2 : 1;
    localparam logic [63:0] MASK = (64'h1 << W) - 64'h1;
    localparam logic [63:0] MSB  = 64'h1 << (W - 1);

    // Directed rows: a, b, cin, sub, sign -> sum, cout, ofl, zero (bit i of the packed masks = row i).
    localparam logic [63:0] DA [8] = '{MASK >> 1, MASK, MASK, 64'd3, 64'd3, MSB, 64'd5, MASK};
    localparam logic [63:0] DB [8] = '{64'd1, 64'd1, 64'd1, 64'd5, 64'd5, 64'd1, 64'd5, 64'd0};
    localparam logic [63:0] ES [8] = '{MSB, 64'd0, 64'd0, MASK - 64'd1, MASK - 64'd1, MASK >> 1, 64'd0, 64'd0};
    localparam logic [7:0] DCIN  = 8'b1100_0000;
    localparam logic [7:0] DSUB  = 8'b0111_1000;
    localparam logic [7:0] DSIGN = 8'b0011_0101;
    localparam logic [7:0] EC    = 8'b1110_0110;
    localparam logic [7:0] EO    = 8'b1010_1011;
    localparam logic [7:0] EZ    = 8'b1100_0110;

    logic         rst, in_valid, in_ready, cin, sub, sign, out_valid, out_ready, cout, ofl, zero;
    logic [W-1:0] a, b, sum;
    bit           done = 1'b0;

    typedef struct {
      logic [63:0] s;
      logic        co, ov, z;
      int          rem;
    } exp_t;
    exp_t q[$];
    bit   eov, adv_m;

    cla_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .sign(sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ofl(ofl), .zero(zero)
    );

    function automatic exp_t model(logic [63:0] av, logic [63:0] bv, logic c_i, logic sb, logic sg);
      logic [63:0] bb, full;
      exp_t e;
      bb    = sb ? (~bv & MASK) : bv;
      full  = av + bb + (sb ? 64'd1 : {63'd0, c_i});
      e.s   = full & MASK;
      e.co  = full[W];
      e.ov  = sg ? ((av[W-1] == bb[W-1]) && (e.s[W-1] != av[W-1])) : (e.co ^ sb);
      e.z   = (e.s == 64'd0);
      e.rem = S - 1;
      return e;
    endfunction

    task automatic rnd_ops();
      a    = (($urandom % 8) == 0) ? W'(MASK) : W'($urandom);
      b    = (($urandom % 8) == 0) ? W'(1) : W'($urandom);
      cin  = 1'($urandom);
      sub  = 1'($urandom);
      sign = 1'($urandom);
    endtask

    // Outputs and handshakes are sampled mid-cycle; the queue is updated for the coming edge.
    always @(negedge clk) begin
      if (rst) q.delete();
      else begin
        eov = (q.size() > 0) && (q[0].rem == 0);
        chk($sformatf("c%0d_out_valid", ci), 64'(out_valid), 64'(eov));
        adv_m = !eov || out_ready;
        chk($sformatf("c%0d_in_ready", ci), 64'(in_ready), 64'(adv_m));
        if (eov && out_valid) begin
          chk($sformatf("c%0d_sum", ci),  64'(sum),  q[0].s);
          chk($sformatf("c%0d_cout", ci), 64'(cout), 64'(q[0].co));
          chk($sformatf("c%0d_ofl", ci),  64'(ofl),  64'(q[0].ov));
          chk($sformatf("c%0d_zero", ci), 64'(zero), 64'(q[0].z));
        end
        if (adv_m) begin
          if (eov) void'(q.pop_front());
          foreach (q[i]) q[i].rem = q[i].rem - 1;
          if (in_valid) q.push_back(model(64'(a), 64'(b), cin, sub, sign));
        end
      end
    end

    initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sign = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk($sformatf("c%0d_rst_valid", ci), 64'(out_valid), 64'd0);
      chk($sformatf("c%0d_rst_sum", ci),   64'(sum),       64'd0);
      chk($sformatf("c%0d_rst_cout", ci),  64'(cout),      64'd0);
      chk($sformatf("c%0d_rst_ofl", ci),   64'(ofl),       64'd0);
      chk($sformatf("c%0d_rst_zero", ci),  64'(zero),      64'd0);
      chk($sformatf("c%0d_rst_ready", ci), 64'(in_ready),  64'd1);

      for (int i = 0; i < 8; i++) begin
        a = W'(DA[i]); b = W'(DB[i]); cin = DCIN[i]; sub = DSUB[i]; sign = DSIGN[i];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
          @(posedge clk);
          #1 lat++;
        end
        chk($sformatf("c%0d_dir%0d_latency", ci, i), 64'(lat), 64'(S));
        chk($sformatf("c%0d_dir%0d_sum", ci, i),  64'(sum),  ES[i]);
        chk($sformatf("c%0d_dir%0d_cout", ci, i), 64'(cout), 64'(EC[i]));
        chk($sformatf("c%0d_dir%0d_ofl", ci, i),  64'(ofl),  64'(EO[i]));
        chk($sformatf("c%0d_dir%0d_zero", ci, i), 64'(zero), 64'(EZ[i]));
        @(posedge clk);
        #1;
      end

      for (int i = 0; i < 8; i++) begin
        rnd_ops();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      repeat (S + 2) @(posedge clk);
      #1;

      for (int i = 0; i < 150; i++) begin
        rnd_ops();
        in_valid  = ($urandom % 4) != 0;
        out_ready = (i >= 20 && i < 25) ? 1'b0 : (($urandom % 4) != 0);
        @(posedge clk);
        #1;
      end

      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        rnd_ops();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      rnd_ops();
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      chk($sformatf("c%0d_midrst_valid", ci), 64'(out_valid), 64'd0);

      for (int i = 0; i < 60; i++) begin
        rnd_ops();
        in_valid  = ($urandom % 3) != 0;
        out_ready = ($urandom % 3) != 0;
        @(posedge clk);
        #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (S + 3) @(posedge clk);
      #1;
      chk($sformatf("c%0d_drained", ci), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
      @(posedge clk);
    end
    chk("all_configs_done", 64'(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done), 64'd1);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the datapath, replacing the fixed 16-bit single-cycle CLA.
- Operand width and pipeline depth are parameters.
- Each pipeline stage resolves one slice with a 4-bit CLA group tree; the carry between slices is registered.
- Provides a valid/ready handshake with backpressure, a subtract mode, real signed/unsigned overflow, and a zero flag, so it can sit between the ALU operand mux and writeback.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and of STAGES.
STAGES, 4, number of pipeline stages (1..WIDTH/4); slice width SW = WIDTH/STAGES; SW must be a multiple of 4.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand set presented this cycle.
in_ready  out  1  block accepts operands this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry in (ignored when sub=1).
sub  in  1  1: compute a - b as a + ~b + 1.
sign  in  1  1: ofl reports two's-complement overflow; 0: unsigned overflow.
out_valid  out  1  result registers hold a valid result.
out_ready  in  1  consumer accepts the result this cycle.
sum  out  WIDTH  result.
cout  out  1  raw carry out of the MSB.
ofl  out  1  overflow per sign/sub.
zero  out  1  sum == 0.

Behaviour:
- Global advance signal: adv = !out_valid | out_ready. in_ready = adv (combinational). All stage registers, including valid bits, shift only when adv=1; otherwise they hold.
- Handshake: a transfer occurs when in_valid & in_ready. Once presented, in_valid/a/b/... need not be held if accepted. When stalled, out_valid/sum/cout/ofl/zero hold stable until out_ready.
- Capture: b_eff = sub ? ~b : b; c_eff = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds slice k of a and b_eff using the carry from stage k-1 (c_eff for k=0). It uses 4-bit group generate/propagate and lookahead within the slice, and registers the slice sum, slice carry-out, and the carry into the slice MSB.
- Not-yet-processed upper slices travel down the pipe with the operation. Completed lower slice sums are carried alongside the operation so the full result aligns at the output register.
- Latency: a result accepted at cycle t appears with out_valid=1 at cycle t+STAGES when there is no stall. Throughput is one operation per cycle while out_ready=1.
- Bubbles (in_valid=0 while adv=1) propagate as valid=0 and are not collapsed.
- ofl: sign=1 gives c_msb_in ^ cout; sign=0 gives cout ^ sub (borrow for subtract).
- zero is computed from the final full sum and registered with it.
- Reset (rst=1 at a clock edge): all valid bits are cleared; out_valid=0, sum=0, cout=0, ofl=0, zero=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial result is emitted.
  - rst has priority over a simultaneous transfer.
- Simultaneous accept and drain when full (out_valid=1, out_ready=1, in_valid=1): the pipe shifts and no operation is lost or duplicated.
- STAGES=1 degenerates to a registered single-cycle CLA with identical flags.
- Wrap-around: sum is modulo 2^WIDTH; carry is reported only via cout/ofl.

Test Plan:
Default params, a=16'h7FFF, b=16'h0001, sub=0, sign=1, cin=0 -> after 4 cycles out_valid=1, sum=16'h8000, cout=0, ofl=1, zero=0.
a=16'hFFFF, b=16'h0001, sub=0, sign=0 -> sum=16'h0000, cout=1, ofl=1, zero=1; with sign=1 the same operands give ofl=0.
sub=1: a=16'h0003, b=16'h0005, sign=0 -> sum=16'hFFFE, cout=0, ofl=1 (borrow); sign=1 -> ofl=0. Also a=16'h8000, b=16'h0001, sign=1 -> sum=16'h7FFF, ofl=1.
Back-to-back stream of 8 random operations with out_ready=1 -> 8 results in order, one per cycle starting at cycle 4, each matching the reference a±b model.
Hold out_ready=0 for 5 cycles while streaming -> in_ready drops once out_valid=1; held outputs stay stable; no loss or duplication after release. Assert rst mid-stream -> out_valid=0 on the next cycle and no stale results afterwards.
Repeat the scenarios with WIDTH=32, STAGES=2 and WIDTH=8, STAGES=1 -> latency equals STAGES and flags match the model, including the carry chain across all slices (a=32'hFFFFFFFF, b=1 -> sum=0, cout=1).
